// File: rtl/approx_divider.sv
// approx_divider: multi-cycle restoring divider with valid/ready handshakes and optional self-check.
// Ports: clk, rst (async, active-high); in_valid/in_ready + dividend/divisor operand handshake;
// out_valid/out_ready + quotient/remainder/div_by_zero/check_err result handshake.
// Optional macro APPROX_DIVIDER_CHECK_EN enables the quotient*divisor+remainder self-check;
// when undefined check_err is tied to 0.
module approx_divider #(
    parameter int DIVIDEND_W = 15,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  check_err
);
    localparam int CW = $clog2(DIVIDEND_W + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [DIVIDEND_W-1:0] dq, dq_nx;
    logic [DIVISOR_W-1:0]  dvs;
    logic [DIVISOR_W:0]    pr, pr_sh, pr_nx;
    logic [CW-1:0]         cnt;
    logic                  ge, accept, last, zero;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign zero      = divisor == '0;
    assign last      = cnt == CW'(DIVIDEND_W - 1);
    // dq starts as the dividend and shifts out MSB-first while quotient bits shift in at the LSB
    assign pr_sh = {pr[DIVISOR_W-1:0], dq[DIVIDEND_W-1]};
    assign ge    = pr_sh >= {1'b0, dvs};
    assign pr_nx = ge ? pr_sh - {1'b0, dvs} : pr_sh;
    assign dq_nx = {dq[DIVIDEND_W-2:0], ge};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (zero ? DONE : CALC) : IDLE;
            CALC:    state_nx = last ? DONE : CALC;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq          <= '0;
            dvs         <= '0;
            pr          <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dq  <= dividend;
            dvs <= divisor;
            pr  <= '0;
            cnt <= '0;
            if (zero) begin
                quotient    <= '1;
                remainder   <= dividend[DIVISOR_W-1:0];
                div_by_zero <= 1'b1;
            end
        end else if (state == CALC) begin
            dq  <= dq_nx;
            pr  <= pr_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
                quotient    <= dq_nx;
                remainder   <= pr_nx[DIVISOR_W-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end
`ifdef APPROX_DIVIDER_CHECK_EN
    localparam int PW = DIVIDEND_W + DIVISOR_W + 1;
    logic [DIVIDEND_W-1:0] dvd0;
    logic [PW-1:0]         recon;
    assign recon = PW'(dq_nx) * PW'(dvs) + PW'(pr_nx);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd0      <= '0;
            check_err <= 1'b0;
        end else if (accept) begin
            dvd0 <= dividend;
            if (zero) check_err <= 1'b0;
        end else if (state == CALC && last) begin
            check_err <= (recon != PW'(dvd0)) || (pr_nx >= {1'b0, dvs});
        end
    end
`else
    assign check_err = 1'b0;
`endif
endmodule

// File: tb/tb_approx_divider.sv
// tb_approx_divider: directed and random checks of approx_divider against hand-computed results.
module tb_approx_divider;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        check_err;
    int          n_checks = 0;
    int          n_fail = 0;
    int          lat;

    approx_divider dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .check_err(check_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one operand pair, scramble the inputs after the accept edge,
    // and count edges after the accept edge until out_valid appears.
    task automatic run_op(input logic [14:0] a, input logic [7:0] b, output int l);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 15'($urandom);
        divisor  = 8'($urandom);
        l = 0;
        while (!out_valid && l < 40) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic finish_op(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_back_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", {17'd0, quotient}, 32'd0);
        check("rst_remainder", {24'd0, remainder}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst_check_err", {31'd0, check_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(15'd200, 8'd7, lat);
        check("200_7_latency", lat, 32'd15);
        check("200_7_q", {17'd0, quotient}, 32'd28);
        check("200_7_r", {24'd0, remainder}, 32'd4);
        check("200_7_dbz", {31'd0, div_by_zero}, 32'd0);
        check("200_7_in_ready", {31'd0, in_ready}, 32'd0);
        finish_op("200_7");

        run_op(15'd32767, 8'd255, lat);
        check("max_q", {17'd0, quotient}, 32'd128);
        check("max_r", {24'd0, remainder}, 32'd127);
        finish_op("max");

        run_op(15'd0, 8'd5, lat);
        check("zero_dvd_q", {17'd0, quotient}, 32'd0);
        check("zero_dvd_r", {24'd0, remainder}, 32'd0);
        finish_op("zero_dvd");

        run_op(15'd100, 8'd0, lat);
        check("dbz_latency", lat, 32'd0);
        check("dbz_q", {17'd0, quotient}, 32'h7FFF);
        check("dbz_r", {24'd0, remainder}, 32'd100);
        check("dbz_flag", {31'd0, div_by_zero}, 32'd1);
        check("dbz_check_err", {31'd0, check_err}, 32'd0);
        finish_op("dbz");

        run_op(15'd9, 8'd9, lat);
        check("dbz_cleared", {31'd0, div_by_zero}, 32'd0);
        check("9_9_q", {17'd0, quotient}, 32'd1);
        check("9_9_r", {24'd0, remainder}, 32'd0);
        finish_op("9_9");

        out_ready = 1'b0;
        run_op(15'd1000, 8'd3, lat);
        check("hold_latency", lat, 32'd15);
        for (int i = 0; i < 5; i++) begin
            check("hold_q", {17'd0, quotient}, 32'd333);
            check("hold_r", {24'd0, remainder}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_valid", {31'd0, out_valid}, 32'd0);
        check("hold_release_ready", {31'd0, in_ready}, 32'd1);
        check("hold_q_after", {17'd0, quotient}, 32'd333);

        @(negedge clk);
        dividend = 15'd1234;
        divisor  = 8'd11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("calc_no_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_quotient", {17'd0, quotient}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat++;
        end
        check("midrst_no_valid", lat, 32'd0);
        check("midrst_idle", {31'd0, in_ready}, 32'd1);
        run_op(15'd50, 8'd6, lat);
        check("50_6_q", {17'd0, quotient}, 32'd8);
        check("50_6_r", {24'd0, remainder}, 32'd2);
        finish_op("50_6");

        for (int i = 0; i < 40; i++) begin
            logic [14:0] a;
            logic [7:0]  b;
            a = 15'($urandom_range(0, 32767));
            b = 8'($urandom_range(1, 255));
            run_op(a, b, lat);
            check("rand_latency", lat, 32'd15);
            check("rand_q", {17'd0, quotient}, 32'(a / b));
            check("rand_r", {24'd0, remainder}, 32'(a % b));
            check("rand_check_err", {31'd0, check_err}, 32'd0);
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
